reg_dump_ctrl: RTL

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

---
 rtl/sccpu_dbg_pkg.sv | 19 +
 rtl/cyc_counter.sv | 31 +++
 rtl/reg_dump_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sccpu_dbg_pkg.sv
// rtl/sccpu_dbg_pkg.sv - shared state encoding and default constants for the register dump controller
package sccpu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CRST = 3'd1,
    ST_RUN  = 3'd2,
    ST_SEL  = 3'd3,
    ST_CAP  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam int DEF_NREG = 32;
  localparam int DEF_DW   = 32;
  localparam int DEF_SELW = 5;
  localparam int DEF_CW   = 16;
  localparam int DEF_RSTC = 2;

endpackage

// File: rtl/cyc_counter.sv
// rtl/cyc_counter.sv - CPU run-cycle counter with clear, enable and match against a target
module cyc_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] target,
  output logic          match
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] count;

  // count enabled cycles; clear wins over enable
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end
  end

  // match flags the enabled cycle whose increment reaches the target
  assign match = ((count + ONE) == target);

endmodule

// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - resets and runs the CPU for a bounded time, then streams out all registers
module reg_dump_ctrl
  import sccpu_dbg_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int DW   = DEF_DW,
  parameter int SELW = DEF_SELW,
  parameter int CW   = DEF_CW,
  parameter int RSTC = DEF_RSTC
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [CW-1:0]   run_cycles,
  input  logic            halt,
  output logic            cpu_rstn,
  output logic            cpu_en,
  output logic [SELW-1:0] reg_sel,
  input  logic [DW-1:0]   reg_data,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [SELW-1:0] dump_idx,
  output logic [DW-1:0]   dump_data,
  output logic            busy,
  output logic            done
);

  localparam int              RW       = (RSTC > 1) ? $clog2(RSTC) : 1;
  localparam logic [RW-1:0]   RST_LAST = RW'(RSTC - 1);
  localparam logic [SELW-1:0] IDX_LAST = SELW'(NREG - 1);

  state_t          state;
  state_t          next;
  logic [CW-1:0]   rc;
  logic [RW-1:0]   rcnt;
  logic [SELW-1:0] idx;
  logic            accept;
  logic            run_en;
  logic            run_match;
  logic            beat_done;
  logic            cpu_rstn_nx;
  logic            cpu_en_nx;

  assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign run_en    = (state == ST_RUN);
  assign beat_done = (state == ST_CAP) && dump_valid && dump_ready;
  assign reg_sel   = idx;

  cyc_counter #(.CW(CW)) u_cyc_counter (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (accept),
    .en     (run_en),
    .target (rc),
    .match  (run_match)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= next;
    end
  end

  // next-state decode
  always_comb begin
    next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) next = ST_CRST;
      ST_CRST: if (rcnt == RST_LAST) next = (rc == '0) ? ST_SEL : ST_RUN;
      ST_RUN:  if (run_match || halt) next = ST_SEL;
      ST_SEL:  next = ST_CAP;
      ST_CAP:  if (beat_done) next = (idx == IDX_LAST) ? ST_DONE : ST_SEL;
      default: next = ST_IDLE;
    endcase
  end

  // status outputs from the current state; CPU controls follow the next state so they are registered
  always_comb begin
    busy        = (state != ST_IDLE) && (state != ST_DONE);
    done        = (state == ST_DONE);
    cpu_rstn_nx = (next != ST_CRST);
    cpu_en_nx   = (next == ST_RUN);
  end

  // datapath: latched run length, reset-hold counter, register index and the output beat
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rc         <= '0;
      rcnt       <= '0;
      idx        <= '0;
      cpu_rstn   <= 1'b0;
      cpu_en     <= 1'b0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      cpu_rstn <= cpu_rstn_nx;
      cpu_en   <= cpu_en_nx;
      if (accept) begin
        rc   <= run_cycles;
        rcnt <= '0;
        idx  <= '0;
      end else begin
        if (state == ST_CRST) rcnt <= rcnt + RW'(1);
        if (beat_done && (idx != IDX_LAST)) idx <= idx + SELW'(1);
      end
      if (state == ST_SEL) begin
        dump_valid <= 1'b1;
        dump_idx   <= idx;
        dump_data  <= reg_data;
      end else if (beat_done) begin
        dump_valid <= 1'b0;
      end
    end
  end

endmodule
